// File: rtl/ifq_if.sv
// Fetch/decode handshake bundle for the instruction fetch queue.
// master: fetch and decode side; slave: the queue.
interface ifq_if #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CntW-1:0]   count;

  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );
endinterface

// File: rtl/ifq.sv
// Instruction fetch queue between fetch and decode, with single-cycle flush.
// Define IFQ_BYPASS_EN for a zero-latency empty-queue bypass from in_* to out_*.
module ifq #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32
) (
  input logic   clk,
  input logic   rst,
  ifq_if.slave  q
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [PC_W+INST_W-1:0] mem_q [DEPTH];

  logic              empty, full;
  logic              in_ready, push, pop, direct, wr_en, rd_en;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign in_ready = rst & ~full;
  assign push     = q.in_valid & in_ready & ~q.flush;
  assign pop      = out_valid & q.out_ready;

  always_comb begin
    out_valid = rst & ~empty & ~q.flush;
    out_pc    = '0;
    out_inst  = '0;
    if (!empty) begin
      {out_pc, out_inst} = mem_q[rd_ptr_q];
    end
`ifdef IFQ_BYPASS_EN
    if (empty && q.in_valid && !q.flush) begin
      out_valid = rst;
      out_pc    = q.in_pc;
      out_inst  = q.in_inst;
    end
`endif
  end

`ifdef IFQ_BYPASS_EN
  // A pop while empty can only be the bypassed pair: it never touches storage.
  assign direct = empty & pop;
`else
  assign direct = 1'b0;
`endif

  assign wr_en = push & ~direct;
  assign rd_en = pop & ~direct;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {q.in_pc, q.in_inst};
    end
  end

  assign q.in_ready  = in_ready;
  assign q.out_valid = out_valid;
  assign q.out_pc    = out_pc;
  assign q.out_inst  = out_inst;
  assign q.count     = count_q;
endmodule

// File: tb/tb_ifq.sv
// Directed self-checking bench for the instruction fetch queue (DEPTH=2).
module tb_ifq;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [31:0] P0 = 32'h8000_0000;
  localparam logic [31:0] P1 = 32'h8000_0004;
  localparam logic [31:0] P2 = 32'h8000_0008;
  localparam logic [31:0] F1 = 32'h8000_1000;
  localparam logic [31:0] F2 = 32'h8000_2000;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;

  ifq_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) bus ();

  ifq #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  task automatic set_in(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = inst_of(pc);
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL rst_in_ready cyc%0d: got %b want 0", i, bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_out_valid cyc%0d: got %b want 0", i, bus.out_valid);
      end
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.count !== 2'd0) begin
      errors++; $display("FAIL post_rst_count: got %0d want 0", bus.count);
    end
    checks++;
    if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0) begin
      errors++; $display("FAIL post_rst_out_data: got %h/%h want 0/0", bus.out_pc, bus.out_inst);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    int          lat;
    int          k;
    logic        ev;
    logic [1:0]  ec;
    pcs[0] = P0; pcs[1] = P1; pcs[2] = P2;
`ifdef IFQ_BYPASS_EN
    lat = 0;
`else
    lat = 1;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_in(i < 3, (i < 3) ? pcs[i] : 32'h0, 1'b1, 1'b0);
      #1;
      k  = i - lat;
      ev = (k >= 0 && k < 3);
      ec = (lat == 1 && i >= 1 && i <= 3) ? 2'd1 : 2'd0;
      checks++;
      if (bus.out_valid !== ev) begin
        errors++; $display("FAIL stream_valid cyc%0d: got %b want %b", i, bus.out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (bus.out_pc !== pcs[k] || bus.out_inst !== inst_of(pcs[k])) begin
          errors++;
          $display("FAIL stream_data cyc%0d: got %h/%h want %h/%h", i, bus.out_pc,
                   bus.out_inst, pcs[k], inst_of(pcs[k]));
        end
      end
      checks++;
      if (bus.count !== ec) begin
        errors++; $display("FAIL stream_count cyc%0d: got %0d want %0d", i, bus.count, ec);
      end
    end
  endtask

  task automatic test_full();
    @(negedge clk); set_in(1'b1, P0, 1'b0, 1'b0); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL full_c1_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk); set_in(1'b1, P1, 1'b0, 1'b0); #1;
    checks++;
    if (bus.count !== 2'd1 || bus.out_pc !== P0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_c2: got count=%0d pc=%h rdy=%b want 1/%h/1", bus.count, bus.out_pc,
               bus.in_ready, P0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); set_in(1'b1, P2, 1'b0, 1'b0); #1;
      checks++;
      if (bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_hold%0d: got count=%0d rdy=%b want 2/0", i, bus.count, bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== P0 || bus.out_inst !== inst_of(P0)) begin
        errors++;
        $display("FAIL full_stable%0d: got v=%b pc=%h want 1/%h", i, bus.out_valid, bus.out_pc, P0);
      end
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b1, 1'b0); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== P0) begin
      errors++; $display("FAIL full_drain0: got v=%b pc=%h want 1/%h", bus.out_valid, bus.out_pc, P0);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b1, 1'b0); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== P1 || bus.count !== 2'd1) begin
      errors++;
      $display("FAIL full_drain1: got v=%b pc=%h cnt=%0d want 1/%h/1", bus.out_valid, bus.out_pc,
               bus.count, P1);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b0, 1'b0); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin
      errors++;
      $display("FAIL full_third_dropped: got v=%b cnt=%0d want 0/0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_simul();
    @(negedge clk); set_in(1'b1, P0, 1'b0, 1'b0); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL simul_c1_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk); set_in(1'b1, P1, 1'b1, 1'b0); #1;
    checks++;
    if (bus.count !== 2'd1 || bus.out_pc !== P0) begin
      errors++; $display("FAIL simul_c2: got cnt=%0d pc=%h want 1/%h", bus.count, bus.out_pc, P0);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b1, 1'b0); #1;
    checks++;
    if (bus.count !== 2'd1 || bus.out_pc !== P1 || bus.out_inst !== inst_of(P1)) begin
      errors++; $display("FAIL simul_c3: got cnt=%0d pc=%h want 1/%h", bus.count, bus.out_pc, P1);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b0, 1'b0); #1;
    checks++;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_c4: got cnt=%0d v=%b want 0/0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] mq[$];
    int          sent;
    int          got;
    int          cyc;
    logic        ev, ir, push, pop, direct;
    logic [31:0] ep;
    logic [31:0] pc;
    sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 80) begin
      @(negedge clk);
      pc = 32'h8000_0100 + 32'(4 * sent);
      set_in(sent < 10, pc, (cyc % 2) == 1, 1'b0);
      #1;
      ir = (mq.size() != 2);
      ev = (mq.size() != 0);
      ep = ev ? mq[0] : 32'h0;
`ifdef IFQ_BYPASS_EN
      if (mq.size() == 0 && sent < 10) begin
        ev = 1'b1;
        ep = pc;
      end
`endif
      checks++;
      if (bus.in_ready !== ir || bus.out_valid !== ev || bus.count !== 2'(mq.size())) begin
        errors++;
        $display("FAIL wrap_ctrl cyc%0d: got rdy=%b v=%b cnt=%0d want %b/%b/%0d", cyc,
                 bus.in_ready, bus.out_valid, bus.count, ir, ev, mq.size());
      end
      if (ev) begin
        checks++;
        if (bus.out_pc !== ep || bus.out_inst !== inst_of(ep)) begin
          errors++;
          $display("FAIL wrap_data cyc%0d: got %h/%h want %h/%h", cyc, bus.out_pc, bus.out_inst,
                   ep, inst_of(ep));
        end
      end
      push   = bus.in_valid & ir;
      pop    = ev & bus.out_ready;
      direct = pop && (mq.size() == 0);
      if (pop && !direct) void'(mq.pop_front());
      if (push && !direct) mq.push_back(pc);
      if (pop) got++;
      if (push) sent++;
      cyc++;
    end
    checks++;
    if (got != 10) begin
      errors++; $display("FAIL wrap_timeout: got %0d pairs want 10", got);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    @(negedge clk); set_in(1'b1, P0, 1'b0, 1'b0);
    @(negedge clk); set_in(1'b1, P1, 1'b0, 1'b0);
    @(negedge clk); set_in(1'b1, F1, 1'b1, 1'b1); #1;
    checks++;
    if (bus.count !== 2'd2 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: got cnt=%0d v=%b want 2/0", bus.count, bus.out_valid);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b0, 1'b0); #1;
    checks++;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got cnt=%0d v=%b want 0/0", bus.count, bus.out_valid);
    end
    @(negedge clk); set_in(1'b1, F2, 1'b0, 1'b0); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_repush_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b1, 1'b0); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== F2 || bus.count !== 2'd1) begin
      errors++;
      $display("FAIL flush_next_pair: got v=%b pc=%h cnt=%0d want 1/%h/1", bus.out_valid,
               bus.out_pc, bus.count, F2);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b0, 1'b0); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin
      errors++;
      $display("FAIL flush_no_stale: got v=%b cnt=%0d want 0/0", bus.out_valid, bus.count);
    end
    @(negedge clk); set_in(1'b1, P0, 1'b0, 1'b0);
    @(negedge clk); set_in(1'b1, F1, 1'b1, 1'b1); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.count !== 2'd1) begin
      errors++;
      $display("FAIL flush_part_cycle: got rdy=%b v=%b cnt=%0d want 1/0/1", bus.in_ready,
               bus.out_valid, bus.count);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b0, 1'b0); #1;
    checks++;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop_in: got cnt=%0d v=%b want 0/0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); set_in(1'b1, P0, 1'b0, 1'b0);
    @(negedge clk); set_in(1'b1, P1, 1'b0, 1'b0);
    @(negedge clk); set_in(1'b0, 32'h0, 1'b0, 1'b0); rst = 1'b0; #1;
    checks++;
    if (bus.count !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_during: got cnt=%0d rdy=%b v=%b want 2/0/0", bus.count, bus.in_ready,
               bus.out_valid);
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_pc !== 32'h0) begin
      errors++;
      $display("FAIL rmid_after: got cnt=%0d v=%b rdy=%b pc=%h want 0/0/1/0", bus.count,
               bus.out_valid, bus.in_ready, bus.out_pc);
    end
    @(negedge clk); set_in(1'b0, 32'h0, 1'b1, 1'b0); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin
      errors++;
      $display("FAIL rmid_no_stale: got v=%b cnt=%0d want 0/0", bus.out_valid, bus.count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_streaming();
    test_full();
    test_simul();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
